// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
package spi_pkg;
    typedef enum logic {IDLE, SHIFT} state_e;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W = $clog2(BYTE_W);
    localparam logic [BYTE_W-1:0] IDLE_FILL = 8'hFF;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus host-side byte interface; overrun exists only with SPI_SLAVE_OVR_EN.
interface spi_slave_if;
    import spi_pkg::*;
    logic sck, ss_n, mosi, miso, miso_oe;
    logic [BYTE_W-1:0] tx_data, rx_data;
    logic tx_load, tx_ready, rx_valid, rx_rd, busy;
`ifdef SPI_SLAVE_OVR_EN
    logic overrun;
    modport slave (input sck, ss_n, mosi, tx_data, tx_load, rx_rd,
                   output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun);
    modport master (output sck, ss_n, mosi, tx_data, tx_load, rx_rd,
                    input miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun);
`else
    modport slave (input sck, ss_n, mosi, tx_data, tx_load, rx_rd,
                   output miso, miso_oe, tx_ready, rx_data, rx_valid, busy);
    modport master (output sck, ss_n, mosi, tx_data, tx_load, rx_rd,
                    input miso, miso_oe, tx_ready, rx_data, rx_valid, busy);
`endif
endinterface

// File: rtl/spi_sync.sv
// spi_sync: two-flop synchronizer with a configurable reset level.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk_i)
        sync_q <= rst_i ? {2{RST_VAL}} : {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-configurable SPI slave with TX holding register and RX byte output.
// Define SPI_SLAVE_OVR_EN to add the sticky overrun flag.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0
) (
    input logic        clk_i,
    input logic        rst_i,
    spi_slave_if.slave bus
);
    logic sck_s, ss_s, mosi_s;
    logic sck_prev_q, ss_prev_q;
    state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BYTE_W-1:0] tx_sr_q, rx_sr_q, hold_q, rx_data_q, tx_next_d;
    logic tx_ready_q, rx_valid_q, busy_q, miso_oe_q, reload_q;
    logic lead, trail, sample, shift_e, ss_fall, last_bit;

    spi_sync #(.RST_VAL(CPOL)) u_sync_sck (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.sck), .q_o(sck_s));
    spi_sync #(.RST_VAL(1'b1)) u_sync_ss (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.ss_n), .q_o(ss_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(clk_i), .rst_i(rst_i), .d_i(bus.mosi), .q_o(mosi_s));

    always_comb begin
        lead = (sck_prev_q == CPOL) && (sck_s != CPOL);
        trail = (sck_prev_q != CPOL) && (sck_s == CPOL);
        sample = CPHA ? trail : lead;
        shift_e = CPHA ? lead : trail;
        ss_fall = ss_prev_q && !ss_s;
        last_bit = cnt_q == CNT_W'(BYTE_W - 1);
        tx_next_d = tx_ready_q ? IDLE_FILL : hold_q;
    end

`ifdef SPI_SLAVE_OVR_EN
    logic unread_q, overrun_q;
    always_ff @(posedge clk_i)
        if (rst_i) begin
            unread_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (state_q == SHIFT && !ss_s && sample && last_bit) begin
            unread_q <= 1'b1;
            if (unread_q && !bus.rx_rd) overrun_q <= 1'b1;
        end else if (bus.rx_rd) begin
            unread_q <= 1'b0;
        end
    assign bus.overrun = overrun_q;
`else
    logic unused_rx_rd;
    assign unused_rx_rd = bus.rx_rd;
`endif

    always_ff @(posedge clk_i)
        if (rst_i) begin
            state_q <= IDLE;
            sck_prev_q <= CPOL;
            ss_prev_q <= 1'b1;
            cnt_q <= '0;
            tx_sr_q <= '0;
            rx_sr_q <= '0;
            hold_q <= '0;
            rx_data_q <= '0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            busy_q <= 1'b0;
            miso_oe_q <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            ss_prev_q <= ss_s;
            rx_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (ss_fall) begin
                    state_q <= SHIFT;
                    tx_sr_q <= tx_next_d;
                    tx_ready_q <= 1'b1;
                    cnt_q <= '0;
                    reload_q <= 1'b0;
                    miso_oe_q <= 1'b1;
                end
            end else if (ss_s) begin
                state_q <= IDLE;
                cnt_q <= '0;
                rx_sr_q <= '0;
                busy_q <= 1'b0;
                reload_q <= 1'b0;
                miso_oe_q <= 1'b0;
            end else begin
                if (sample) begin
                    rx_sr_q <= {rx_sr_q[BYTE_W-2:0], mosi_s};
                    cnt_q <= cnt_q + 1'b1;
                    busy_q <= !last_bit;
                    if (last_bit) begin
                        rx_data_q <= {rx_sr_q[BYTE_W-2:0], mosi_s};
                        rx_valid_q <= 1'b1;
                        reload_q <= 1'b1;
                    end
                end
                // The next byte is fetched on the first shift edge after completion,
                // giving the host time to refill after RxValid.
                if (shift_e && cnt_q != '0) begin
                    tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
                end else if (shift_e && reload_q) begin
                    tx_sr_q <= tx_next_d;
                    tx_ready_q <= 1'b1;
                    reload_q <= 1'b0;
                end
            end
            // Placed last so a write on the same cycle as a fetch from an empty holding register survives.
            if (bus.tx_load && tx_ready_q) begin
                hold_q <= bus.tx_data;
                tx_ready_q <= 1'b0;
            end
        end

    assign bus.miso = miso_oe_q & tx_sr_q[BYTE_W-1];
    assign bus.miso_oe = miso_oe_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy = busy_q;
endmodule
